ne16_binconv_block_ctrl: RTL and testbench

NE16_BINCONV_BLOCK_CTRL -- requirements
Module: ne16_binconv_block_ctrl

---
 rtl/ne16_binconv_block_ctrl_if.sv | 9 +
 rtl/ne16_binconv_block_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ne16_binconv_block_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ne16_binconv_block_ctrl_if.sv
// Block-result handshake seen by the binconv block controller.
// The controller only observes the handshake, so both signals are inputs on its side.
interface ne16_binconv_block_ctrl_if;
  logic pres_valid;
  logic pres_ready;

  modport master (output pres_valid, output pres_ready);
  modport slave  (input  pres_valid, input  pres_ready);
endinterface

// File: rtl/ne16_binconv_block_ctrl.sv
// NE16 binary-convolution block controller: clear, one accumulation pass per weight bit,
// optional weight-offset pass (present only when NE16_BINCONV_CTRL_WOFFS_EN is defined).
module ne16_binconv_block_ctrl #(
  parameter  int unsigned BLOCK_SIZE = 4,
  parameter  int unsigned N_SHIFTS   = 8,
  localparam int unsigned SW         = (N_SHIFTS > 1) ? $clog2(N_SHIFTS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [SW-1:0]         cfg_qw_i,
  input  logic [7:0]            cfg_beats_i,
  input  logic                  cfg_mode_16_i,
  input  logic                  cfg_mode_linear_i,
  input  logic                  cfg_woffs_i,
  input  logic [1:0]            cfg_filter_mode_i,
  input  logic [SW-1:0]         cfg_scale_shift_i,
  input  logic [BLOCK_SIZE-1:0] cfg_enable_mac_i,
  ne16_binconv_block_ctrl_if.slave pres,
  output logic                  enable_o,
  output logic                  ctrl_clear_o,
  output logic                  ctrl_weight_offset_o,
  output logic                  ctrl_invalidate_o,
  output logic                  ctrl_mode_16_o,
  output logic [SW-1:0]         ctrl_block_cnt_o,
  output logic [SW-1:0]         ctrl_shift_sel_o,
  output logic [BLOCK_SIZE-1:0] ctrl_enable_mac_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [1:0] FILTER_3X3_DW = 2'b01;
  localparam logic [1:0] FILTER_1X1    = 2'b10;

`ifdef NE16_BINCONV_CTRL_WOFFS_EN
  typedef enum logic [2:0] {IDLE, CLEAR, BITS, OFFSET, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, CLEAR, BITS, DONE} state_e;
`endif

  typedef struct packed {
    logic [SW-1:0]         qw;
    logic [7:0]            beats;
    logic                  mode_16;
    logic                  linear;
    logic [1:0]            filter;
    logic [SW-1:0]         shift;
    logic [BLOCK_SIZE-1:0] mac;
  } cfg_t;

  typedef struct packed {
    logic                  enable;
    logic                  clear;
    logic                  woffs;
    logic                  invalidate;
    logic                  mode_16;
    logic                  busy;
    logic                  done;
    logic [SW-1:0]         block_cnt;
    logic [SW-1:0]         shift_sel;
    logic [BLOCK_SIZE-1:0] mac;
  } out_t;

  state_e        state_q, state_n;
  logic [SW-1:0] bit_q, bit_n;
  logic [7:0]    beat_q, beat_n;
  cfg_t          cfg_q, cfg_n;
  out_t          out_q, out_n;
  logic          armed_q;
  logic          fire;

`ifdef NE16_BINCONV_CTRL_WOFFS_EN
  logic woffs_q, woffs_n;
`else
  logic unused_woffs;
  assign unused_woffs = cfg_woffs_i;
`endif

  assign fire = pres.pres_valid & pres.pres_ready;

  always_comb begin
    state_n = state_q;
    bit_n   = bit_q;
    beat_n  = beat_q;
    cfg_n   = cfg_q;
`ifdef NE16_BINCONV_CTRL_WOFFS_EN
    woffs_n = woffs_q;
`endif
    if (abort_i) begin
      state_n = IDLE;
      bit_n   = '0;
      beat_n  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // armed_q blocks a start that coincides with reset release
          if (start_i && armed_q) begin
            cfg_n   = '{qw: cfg_qw_i, beats: cfg_beats_i, mode_16: cfg_mode_16_i,
                        linear: cfg_mode_linear_i, filter: cfg_filter_mode_i,
                        shift: cfg_scale_shift_i, mac: cfg_enable_mac_i};
`ifdef NE16_BINCONV_CTRL_WOFFS_EN
            woffs_n = cfg_woffs_i;
`endif
            state_n = CLEAR;
          end
        end
        CLEAR: begin
          state_n = BITS;
          bit_n   = '0;
          beat_n  = '0;
        end
        BITS: begin
          if (fire) begin
            if (beat_q == cfg_q.beats) begin
              beat_n = '0;
              if (bit_q == cfg_q.qw) begin
                bit_n   = '0;
`ifdef NE16_BINCONV_CTRL_WOFFS_EN
                state_n = woffs_q ? OFFSET : DONE;
`else
                state_n = DONE;
`endif
              end else begin
                bit_n = bit_q + SW'(1);
              end
            end else begin
              beat_n = beat_q + 8'd1;
            end
          end
        end
`ifdef NE16_BINCONV_CTRL_WOFFS_EN
        OFFSET: begin
          if (fire) begin
            if (beat_q == cfg_q.beats) begin
              beat_n  = '0;
              state_n = DONE;
            end else begin
              beat_n = beat_q + 8'd1;
            end
          end
        end
`endif
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    out_n            = '0;
    out_n.busy       = (state_n != IDLE);
    out_n.enable     = (state_n == CLEAR) || (state_n == BITS);
    out_n.clear      = (state_n == CLEAR);
    out_n.done       = (state_n == DONE);
    out_n.invalidate = (state_n != BITS);
    out_n.block_cnt  = (state_n == BITS) ? bit_n : '0;
    out_n.mac        = out_n.busy ? cfg_n.mac : '0;
    out_n.mode_16    = out_n.busy & cfg_n.mode_16;
    out_n.shift_sel  = out_n.block_cnt;
    if (!cfg_n.linear && cfg_n.filter == FILTER_1X1) out_n.shift_sel = cfg_n.shift;
`ifdef NE16_BINCONV_CTRL_WOFFS_EN
    out_n.woffs      = (state_n == OFFSET);
    if (state_n == OFFSET) begin
      out_n.enable     = 1'b1;
      out_n.invalidate = 1'b0;
      if (cfg_n.filter == FILTER_3X3_DW) out_n.shift_sel = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bit_q   <= '0;
      beat_q  <= '0;
      cfg_q   <= '0;
      out_q   <= '0;
      armed_q <= 1'b0;
`ifdef NE16_BINCONV_CTRL_WOFFS_EN
      woffs_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      bit_q   <= bit_n;
      beat_q  <= beat_n;
      cfg_q   <= cfg_n;
      armed_q <= 1'b1;
      out_q   <= armed_q ? out_n : '0;
`ifdef NE16_BINCONV_CTRL_WOFFS_EN
      woffs_q <= woffs_n;
`endif
    end
  end

  assign enable_o             = out_q.enable;
  assign ctrl_clear_o         = out_q.clear | (abort_i & armed_q);
  assign ctrl_weight_offset_o = out_q.woffs;
  assign ctrl_invalidate_o    = out_q.invalidate;
  assign ctrl_mode_16_o       = out_q.mode_16;
  assign ctrl_block_cnt_o     = out_q.block_cnt;
  assign ctrl_shift_sel_o     = out_q.shift_sel;
  assign ctrl_enable_mac_o    = out_q.mac;
  assign busy_o               = out_q.busy;
  assign done_o               = out_q.done;

endmodule

// File: tb/tb_ne16_binconv_block_ctrl.sv
// Scoreboard bench for ne16_binconv_block_ctrl: expected beats are queued per job and
// popped on each observed result handshake; latency, abort and reset are checked per job.
`timescale 1ns/1ps
module tb_ne16_binconv_block_ctrl;
  localparam int unsigned BLOCK_SIZE = 4;
  localparam int unsigned N_SHIFTS   = 8;
  localparam int unsigned SW         = 3;
  localparam logic [1:0]  F_3X3      = 2'b00;
  localparam logic [1:0]  F_DW       = 2'b01;
  localparam logic [1:0]  F_1X1      = 2'b10;
`ifdef NE16_BINCONV_CTRL_WOFFS_EN
  localparam bit WOFFS_EN = 1'b1;
`else
  localparam bit WOFFS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [SW-1:0] cfg_qw, cfg_shift;
  logic [7:0] cfg_beats;
  logic cfg_m16, cfg_lin, cfg_woffs;
  logic [1:0] cfg_filter;
  logic [BLOCK_SIZE-1:0] cfg_mac;
  logic enable, clear, woffs_o, inval, m16_o, busy, done;
  logic [SW-1:0] block_cnt, shift_sel;
  logic [BLOCK_SIZE-1:0] mac_o;

  ne16_binconv_block_ctrl_if pres_if ();

  ne16_binconv_block_ctrl #(.BLOCK_SIZE(BLOCK_SIZE), .N_SHIFTS(N_SHIFTS)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .cfg_qw_i(cfg_qw), .cfg_beats_i(cfg_beats), .cfg_mode_16_i(cfg_m16),
    .cfg_mode_linear_i(cfg_lin), .cfg_woffs_i(cfg_woffs), .cfg_filter_mode_i(cfg_filter),
    .cfg_scale_shift_i(cfg_shift), .cfg_enable_mac_i(cfg_mac), .pres(pres_if),
    .enable_o(enable), .ctrl_clear_o(clear), .ctrl_weight_offset_o(woffs_o),
    .ctrl_invalidate_o(inval), .ctrl_mode_16_o(m16_o), .ctrl_block_cnt_o(block_cnt),
    .ctrl_shift_sel_o(shift_sel), .ctrl_enable_mac_o(mac_o), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned bc; int unsigned wo; int unsigned shift; } beat_t;
  typedef struct {
    int unsigned qw, beats, woffs, filter, lin, shift, mac, m16;
  } job_t;

  beat_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned exp_shift(input job_t j, input int unsigned bc, input bit offs);
    if (j.filter == 32'(F_DW) && offs) return 0;
    if (j.lin == 0 && j.filter == 32'(F_1X1)) return j.shift;
    return bc;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (!rst && done) done_cnt++;
    if (!rst && !abort && busy && !inval && pres_if.pres_valid && pres_if.pres_ready
        && sb.size() != 0) begin
      e = sb.pop_front();
      check_val("sb_block_cnt", 32'(block_cnt), e.bc);
      check_val("sb_weight_offset", 32'(woffs_o), e.wo);
      check_val("sb_shift_sel", 32'(shift_sel), e.shift);
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_enable"}, 32'(enable), 0);
    check_val({tag, "_invalidate"}, 32'(inval), 0);
    check_val({tag, "_clear"}, 32'(clear), 0);
    check_val({tag, "_mac"}, 32'(mac_o), 0);
    check_val({tag, "_woffs"}, 32'(woffs_o), 0);
  endtask

  // Release reset with start held high on the release cycle; that start must be ignored.
  task automatic release_with_start();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1;
    cfg_qw = 3'd1; cfg_beats = 8'd0; cfg_mac = 4'hF;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_all_zero("post_release");
    @(posedge clk); #1;
    @(negedge clk);
    check_val("release_start_ignored", 32'(busy), 0);
    check_val("idle_invalidate", 32'(inval), 1);
  endtask

  task automatic run_job(input job_t j, input int unsigned stall_at, input int unsigned stall_len,
                         input int unsigned abort_at, input int unsigned rst_at);
    int unsigned cyc, exp_cyc, done0, stall_bc;
    bit offs_on, finished;
    offs_on = WOFFS_EN && (j.woffs != 0);
    for (int unsigned b = 0; b <= j.qw; b++)
      for (int unsigned k = 0; k <= j.beats; k++)
        sb.push_back('{bc: b, wo: 0, shift: exp_shift(j, b, 1'b0)});
    if (offs_on)
      for (int unsigned k = 0; k <= j.beats; k++)
        sb.push_back('{bc: 0, wo: 1, shift: exp_shift(j, 0, 1'b1)});
    exp_cyc = 2 + (j.qw + 1) * (j.beats + 1) + (offs_on ? j.beats + 1 : 0) + stall_len;
    done0 = done_cnt;
    stall_bc = 0;

    @(posedge clk); #1;
    cfg_qw = SW'(j.qw); cfg_beats = 8'(j.beats); cfg_woffs = j.woffs[0];
    cfg_filter = 2'(j.filter); cfg_lin = j.lin[0]; cfg_shift = SW'(j.shift);
    cfg_mac = BLOCK_SIZE'(j.mac); cfg_m16 = j.m16[0];
    start = 1'b1; pres_if.pres_valid = 1'b1; pres_if.pres_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // later config changes must not disturb the running job
    cfg_qw = ~cfg_qw; cfg_beats = cfg_beats + 8'd3; cfg_woffs = ~cfg_woffs;
    cfg_filter = ~cfg_filter; cfg_lin = ~cfg_lin; cfg_shift = ~cfg_shift;
    cfg_mac = ~cfg_mac; cfg_m16 = ~cfg_m16;

    finished = 1'b0;
    cyc = 1;
    while (!finished && cyc <= 80) begin
      pres_if.pres_ready = !(stall_len != 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      abort = (cyc == abort_at);
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        sb.delete();
        finished = 1'b1;
      end else begin
        @(negedge clk);
        if (cyc == 1) begin
          check_val("clear_pulse", 32'(clear), 1);
          check_val("clear_enable", 32'(enable), 1);
          check_val("clear_invalidate", 32'(inval), 1);
        end
        if (cyc == 2 && abort_at != 2) begin
          check_val("bits_clear_low", 32'(clear), 0);
          check_val("bits_invalidate", 32'(inval), 0);
        end
        if (busy) begin
          check_val("busy_mac", 32'(mac_o), j.mac);
          check_val("busy_mode16", 32'(m16_o), j.m16);
          if (j.filter == 32'(F_1X1) && j.lin == 0)
            check_val("shift_const", 32'(shift_sel), j.shift);
        end
        if (stall_len != 0 && cyc >= stall_at && cyc < stall_at + stall_len) begin
          if (cyc == stall_at) stall_bc = 32'(block_cnt);
          else check_val("stall_frozen", 32'(block_cnt), stall_bc);
        end
        if (rst_at != 0 && cyc + 1 == rst_at) begin
          check_val("pre_rst_busy", 32'(busy), 1);
          if (offs_on) check_val("pre_rst_offset", 32'(woffs_o), 1);
        end
        if (cyc == abort_at) begin
          check_val("abort_clear", 32'(clear), 1);
          check_val("abort_bit", 32'(block_cnt), 2);
        end
        if (abort_at != 0 && cyc == abort_at + 1) begin
          check_val("abort_idle_busy", 32'(busy), 0);
          check_val("abort_idle_inval", 32'(inval), 1);
          sb.delete();
        end
        if (abort_at != 0 && cyc == abort_at + 3) finished = 1'b1;
        if (done) begin
          check_val("done_latency", cyc, exp_cyc);
          check_val("done_enable", 32'(enable), 0);
          finished = 1'b1;
        end
        if (!finished) begin
          @(posedge clk); #1;
          cyc++;
        end
      end
    end
    abort = 1'b0;
    pres_if.pres_ready = 1'b1;

    if (rst_at != 0) begin
      release_with_start();
      check_val("rst_no_done", done_cnt - done0, 0);
    end else if (abort_at != 0) begin
      check_val("abort_no_done", done_cnt - done0, 0);
    end else begin
      if (!finished) check_val("done_latency", cyc, exp_cyc);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("done_count", done_cnt - done0, 1);
      check_val("sb_drained", sb.size(), 0);
      check_val("idle_busy", 32'(busy), 0);
      check_val("idle_mac", 32'(mac_o), 0);
      check_val("idle_done", 32'(done), 0);
    end
  endtask

  initial begin
    job_t j;
    rst = 1'b1; start = 1'b0; abort = 1'b1;
    cfg_qw = '0; cfg_beats = '0; cfg_m16 = 1'b0; cfg_lin = 1'b0; cfg_woffs = 1'b0;
    cfg_filter = '0; cfg_shift = '0; cfg_mac = '0;
    pres_if.pres_valid = 1'b1; pres_if.pres_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    abort = 1'b0;
    release_with_start();

    // 4 weight bits, 2 beats each, done 10 cycles after start
    j = '{qw: 3, beats: 1, woffs: 0, filter: 32'(F_3X3), lin: 1, shift: 0, mac: 4'b1011, m16: 1};
    run_job(j, 0, 0, 0, 0);

    j = '{qw: 0, beats: 0, woffs: 1, filter: 32'(F_3X3), lin: 1, shift: 2, mac: 4'b0110, m16: 0};
    run_job(j, 0, 0, 0, 0);

    j = '{qw: 2, beats: 1, woffs: 1, filter: 32'(F_DW), lin: 0, shift: 6, mac: 4'b0001, m16: 1};
    run_job(j, 0, 0, 0, 0);

    j = '{qw: 3, beats: 1, woffs: 0, filter: 32'(F_3X3), lin: 0, shift: 0, mac: 4'b1100, m16: 0};
    run_job(j, 4, 5, 0, 0);

    j = '{qw: 3, beats: 1, woffs: 0, filter: 32'(F_3X3), lin: 1, shift: 0, mac: 4'b1111, m16: 1};
    run_job(j, 0, 0, 6, 0);
    run_job(j, 0, 0, 0, 0);

    j = '{qw: 2, beats: 2, woffs: 1, filter: 32'(F_1X1), lin: 0, shift: 5, mac: 4'b1010, m16: 0};
    run_job(j, 0, 0, 0, 0);

    j = '{qw: 0, beats: 2, woffs: 1, filter: 32'(F_3X3), lin: 1, shift: 0, mac: 4'b0101, m16: 1};
    run_job(j, 0, 0, 0, WOFFS_EN ? 6 : 4);

    j = '{qw: 1, beats: 0, woffs: 1, filter: 32'(F_1X1), lin: 1, shift: 7, mac: 4'b0011, m16: 0};
    run_job(j, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
